// File: rtl/pe_tile_param.sv
// pe_tile_param: parametrised processing-element tile for the island-style fabric.
// Holds a disjoint switch box with optional per-output pipeline registers, two
// connect boxes (sides 0 and 1) feeding a two-operand CLB, and double-buffered
// configuration. Writes land in shadow registers. A commit copies every shadow
// register into its active counterpart on the same edge. Only the active copies
// steer the datapath.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   tile_id        address of this tile, compared with config_addr[15:0]
//   config_addr    [15:0] tile id, [31:16] sub-block id
//   config_data    configuration write data (low bits used)
//   config_valid   configuration write / commit strobe
//   config_read    configuration read strobe (independent of config_valid)
//   config_rdata   shadow readback, valid one cycle after the read strobe
//   config_rvalid  readback valid pulse
//   in_tracks      side s, track t at [(s*NUM_TRACKS+t)*DATA_WIDTH +: DATA_WIDTH]
//   out_tracks     same packing as in_tracks
//   pe_out         CLB result
module pe_tile_param #(
    parameter int DATA_WIDTH = 1,
    parameter int NUM_TRACKS = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [15:0]                        tile_id,
    input  logic [31:0]                        config_addr,
    input  logic [31:0]                        config_data,
    input  logic                               config_valid,
    input  logic                               config_read,
    output logic [31:0]                        config_rdata,
    output logic                               config_rvalid,
    input  logic [4*NUM_TRACKS*DATA_WIDTH-1:0] in_tracks,
    output logic [4*NUM_TRACKS*DATA_WIDTH-1:0] out_tracks,
    output logic [DATA_WIDTH-1:0]              pe_out
);

    localparam int CB_SEL_W = $clog2(2*NUM_TRACKS);
    localparam int SB_N     = 4*NUM_TRACKS;
    localparam int SIDE_W   = NUM_TRACKS*DATA_WIDTH;
    localparam int SB_BASE  = 8;

    localparam logic [15:0] ID_CLB    = 16'd4;
    localparam logic [15:0] ID_CB1    = 16'd5;
    localparam logic [15:0] ID_CB0    = 16'd6;
    localparam logic [15:0] ID_COMMIT = 16'hFFFF;

    // ------------------------------------------------------------------
    // Configuration decode
    // ------------------------------------------------------------------
    logic [15:0] sub_id;
    logic        hit;
    logic        wr_en;
    logic        commit_en;
    logic        rd_en;

    assign sub_id    = config_addr[31:16];
    assign hit       = (config_addr[15:0] == tile_id);
    assign wr_en     = config_valid & hit;
    assign commit_en = wr_en & (sub_id == ID_COMMIT);
    assign rd_en     = config_read & hit;

    // Upper write-data bits are never stored.
    logic unused_cfg;
    assign unused_cfg = &{1'b0, config_data[31:4]};

    // ------------------------------------------------------------------
    // Shadow and active configuration registers
    // ------------------------------------------------------------------
    logic [2:0]          clb_shadow;
    logic [CB_SEL_W-1:0] cb0_shadow;
    logic [CB_SEL_W-1:0] cb1_shadow;
    logic [3:0]          sb_shadow [SB_N];

    logic [2:0]          clb_active;
    logic [CB_SEL_W-1:0] cb0_active;
    logic [CB_SEL_W-1:0] cb1_active;
    logic [3:0]          sb_active [SB_N];

    // Unmapped ids (including commit) fall through every compare and write nothing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clb_shadow <= '0;
            cb0_shadow <= '0;
            cb1_shadow <= '0;
            for (int i = 0; i < SB_N; i++) begin
                sb_shadow[i] <= '0;
            end
        end else if (wr_en) begin
            if (sub_id == ID_CLB) begin
                clb_shadow <= config_data[2:0];
            end
            if (sub_id == ID_CB1) begin
                cb1_shadow <= config_data[CB_SEL_W-1:0];
            end
            if (sub_id == ID_CB0) begin
                cb0_shadow <= config_data[CB_SEL_W-1:0];
            end
            for (int i = 0; i < SB_N; i++) begin
                if (sub_id == 16'(SB_BASE + i)) begin
                    sb_shadow[i] <= config_data[3:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clb_active <= '0;
            cb0_active <= '0;
            cb1_active <= '0;
            for (int i = 0; i < SB_N; i++) begin
                sb_active[i] <= '0;
            end
        end else if (commit_en) begin
            clb_active <= clb_shadow;
            cb0_active <= cb0_shadow;
            cb1_active <= cb1_shadow;
            for (int i = 0; i < SB_N; i++) begin
                sb_active[i] <= sb_shadow[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Readback: the shadow value is sampled before any same-edge write lands
    // ------------------------------------------------------------------
    logic [31:0] rd_val;

    always_comb begin
        rd_val = '0;
        if (sub_id == ID_CLB) begin
            rd_val = 32'(clb_shadow);
        end
        if (sub_id == ID_CB1) begin
            rd_val = 32'(cb1_shadow);
        end
        if (sub_id == ID_CB0) begin
            rd_val = 32'(cb0_shadow);
        end
        for (int i = 0; i < SB_N; i++) begin
            if (sub_id == 16'(SB_BASE + i)) begin
                rd_val = 32'(sb_shadow[i]);
            end
        end
    end

    // ---- stage p1: readback register ----
    logic [31:0] rd_data_p1;
    logic        rd_vld_p1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_p1 <= '0;
            rd_vld_p1  <= 1'b0;
        end else begin
            rd_data_p1 <= rd_en ? rd_val : '0;
            rd_vld_p1  <= rd_en;
        end
    end

    assign config_rdata  = rd_data_p1;
    assign config_rvalid = rd_vld_p1;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    function automatic logic [DATA_WIDTH-1:0] clb_alu(
        input logic [1:0]            op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH-1:0] r;
        case (op)
            2'd0:    r = a & b;
            2'd1:    r = a | b;
            2'd2:    r = a ^ b;
            default: r = a + b;   // carry out of DATA_WIDTH is dropped
        endcase
        return r;
    endfunction

    // Selector values past the last out-track (non power-of-two track counts) give 0.
    function automatic logic [DATA_WIDTH-1:0] cb_pick(
        input logic [CB_SEL_W-1:0] sel,
        input logic [SIDE_W-1:0]   ins,
        input logic [SIDE_W-1:0]   outs
    );
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int j = 0; j < NUM_TRACKS; j++) begin
            if (sel == CB_SEL_W'(j)) begin
                r = ins[j*DATA_WIDTH +: DATA_WIDTH];
            end
            if (sel == CB_SEL_W'(NUM_TRACKS + j)) begin
                r = outs[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Connect boxes and CLB
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] op0;
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] pe_comb;

    assign op0     = cb_pick(cb0_active, in_tracks[0 +: SIDE_W], out_tracks[0 +: SIDE_W]);
    assign op1     = cb_pick(cb1_active, in_tracks[SIDE_W +: SIDE_W], out_tracks[SIDE_W +: SIDE_W]);
    assign pe_comb = clb_alu(clb_active[1:0], op0, op1);

    // ---- stage p1: optional CLB output register ----
    logic [DATA_WIDTH-1:0] pe_p1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pe_p1 <= '0;
        end else begin
            pe_p1 <= pe_comb;
        end
    end

    assign pe_out = clb_active[2] ? pe_p1 : pe_comb;

    // ------------------------------------------------------------------
    // Switch box: one mux and one pipeline register per output track
    // ------------------------------------------------------------------
    for (genvar s = 0; s < 4; s++) begin : g_side
        for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_track
            localparam int IDX = s*NUM_TRACKS + t;
            localparam int SRC1 = (((s + 1) % 4)*NUM_TRACKS + t)*DATA_WIDTH;
            localparam int SRC2 = (((s + 2) % 4)*NUM_TRACKS + t)*DATA_WIDTH;
            localparam int SRC3 = (((s + 3) % 4)*NUM_TRACKS + t)*DATA_WIDTH;

            logic [3:0]            entry;
            logic [DATA_WIDTH-1:0] src;
            logic [DATA_WIDTH-1:0] pipe_p1;

            assign entry = sb_active[IDX];

            always_comb begin
                src = '0;
                case (entry[2:0])
                    3'd1:    src = in_tracks[SRC1 +: DATA_WIDTH];
                    3'd2:    src = in_tracks[SRC2 +: DATA_WIDTH];
                    3'd3:    src = in_tracks[SRC3 +: DATA_WIDTH];
                    3'd4:    src = pe_out;
                    default: src = '0;
                endcase
            end

            // ---- stage p1: switch-box output register ----
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    pipe_p1 <= '0;
                end else begin
                    pipe_p1 <= src;
                end
            end

            assign out_tracks[IDX*DATA_WIDTH +: DATA_WIDTH] = entry[3] ? pipe_p1 : src;
        end
    end

endmodule

// File: tb/tb_pe_tile_param.sv
// Testbench for pe_tile_param (DATA_WIDTH=8, NUM_TRACKS=4): directed steps
// followed by randomized configurations, checked against a behavioural model
// that keeps configuration as id-indexed arrays and resolves the datapath by
// fixed-point evaluation.
module tb_pe_tile_param;

    localparam int DW = 8;
    localparam int NT = 4;
    localparam int W  = 4*NT*DW;
    localparam int NSB = 4*NT;
    localparam logic [15:0] TILE = 16'h0042;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   tile_id;
    logic [31:0]   config_addr;
    logic [31:0]   config_data;
    logic          config_valid;
    logic          config_read;
    logic [31:0]   config_rdata;
    logic          config_rvalid;
    logic [W-1:0]  in_tracks;
    logic [W-1:0]  out_tracks;
    logic [DW-1:0] pe_out;

    int compared   = 0;
    int mismatched = 0;

    pe_tile_param #(.DATA_WIDTH(DW), .NUM_TRACKS(NT)) dut (
        .clk          (clk),
        .reset        (reset),
        .tile_id      (tile_id),
        .config_addr  (config_addr),
        .config_data  (config_data),
        .config_valid (config_valid),
        .config_read  (config_read),
        .config_rdata (config_rdata),
        .config_rvalid(config_rvalid),
        .in_tracks    (in_tracks),
        .out_tracks   (out_tracks),
        .pe_out       (pe_out)
    );

    always #5 clk = ~clk;

    // Reference model state, indexed by sub-block id (0..8+NSB-1).
    int            m_sh  [8+NSB];
    int            m_act [8+NSB];
    logic [DW-1:0] m_sbp [NSB];
    logic [DW-1:0] m_pep;
    logic          m_rvld;
    logic [31:0]   m_rdata;
    logic [DW-1:0] e_out [NSB];
    logic [DW-1:0] e_src [NSB];
    logic [DW-1:0] e_pe;
    logic [DW-1:0] e_pec;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_mapped(int id);
        return id == 4 || id == 5 || id == 6 || (id >= 8 && id < 8 + NSB);
    endfunction

    function automatic int field_mask(int id);
        if (id == 4) return 7;
        if (id == 5 || id == 6) return (1 << $clog2(2*NT)) - 1;
        return 15;
    endfunction

    function automatic logic [DW-1:0] tin(int s, int t);
        return in_tracks[(s*NT + t)*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] alu(int op, logic [DW-1:0] a, logic [DW-1:0] b);
        case (op)
            0:       return a & b;
            1:       return a | b;
            2:       return a ^ b;
            default: return DW'((int'(a) + int'(b)) % (1 << DW));
        endcase
    endfunction

    function automatic logic [W-1:0] rand_tracks();
        logic [W-1:0] v;
        for (int i = 0; i < W/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 8 + NSB; i++) begin
            m_sh[i]  = 0;
            m_act[i] = 0;
        end
        for (int i = 0; i < NSB; i++) m_sbp[i] = '0;
        m_pep   = '0;
        m_rvld  = 1'b0;
        m_rdata = '0;
    endfunction

    // Iterate the routing rules until settled; loop-free configs settle in a few passes.
    function automatic void model_eval();
        logic [DW-1:0] op [2];
        int sel;
        int e;
        for (int i = 0; i < NSB; i++) begin
            e_out[i] = '0;
            e_src[i] = '0;
        end
        e_pe  = '0;
        e_pec = '0;
        repeat (6) begin
            for (int k = 0; k < 2; k++) begin
                sel = m_act[(k == 0) ? 6 : 5];
                if (sel < NT) op[k] = tin(k, sel);
                else          op[k] = e_out[k*NT + sel - NT];
            end
            e_pec = alu(m_act[4] & 3, op[0], op[1]);
            e_pe  = ((m_act[4] & 4) != 0) ? m_pep : e_pec;
            for (int i = 0; i < NSB; i++) begin
                e   = m_act[8 + i];
                sel = e & 7;
                if (sel >= 1 && sel <= 3) e_src[i] = tin(((i / NT) + sel) % 4, i % NT);
                else if (sel == 4)        e_src[i] = e_pe;
                else                      e_src[i] = '0;
                e_out[i] = ((e & 8) != 0) ? m_sbp[i] : e_src[i];
            end
        end
    endfunction

    function automatic void model_edge();
        int id;
        bit hit;
        model_eval();
        for (int i = 0; i < NSB; i++) m_sbp[i] = e_src[i];
        m_pep = e_pec;
        id  = int'(config_addr[31:16]);
        hit = (config_addr[15:0] == tile_id);
        m_rvld = config_read && hit;
        if (m_rvld) m_rdata = is_mapped(id) ? 32'(m_sh[id]) : 32'd0;
        if (config_valid && hit) begin
            if (is_mapped(id)) m_sh[id] = int'(config_data) & field_mask(id);
            else if (id == 'hFFFF) begin
                for (int i = 0; i < 8 + NSB; i++) m_act[i] = m_sh[i];
            end
        end
    endfunction

    task automatic check_all();
        logic [W-1:0] exp_out;
        model_eval();
        for (int i = 0; i < NSB; i++) exp_out[i*DW +: DW] = e_out[i];
        chk("out_tracks", out_tracks, exp_out);
        chk("pe_out", W'(pe_out), W'(e_pe));
        chk("rvalid", W'(config_rvalid), W'(m_rvld));
        if (m_rvld) chk("rdata", W'(config_rdata), W'(m_rdata));
    endtask

    // Entered just after a rising edge; checks mid-cycle, advances one edge.
    task automatic step();
        #2;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cfg_write(input int id, input int val);
        config_addr  = {16'(id), TILE};
        config_data  = 32'(val);
        config_valid = 1'b1;
        step();
        config_valid = 1'b0;
    endtask

    task automatic cfg_read(input int id);
        config_addr = {16'(id), TILE};
        config_read = 1'b1;
        step();
        config_read = 1'b0;
    endtask

    task automatic do_reset();
        config_valid = 1'b0;
        config_read  = 1'b0;
        reset        = 1'b0;
        model_clear();
        #2;
        chk("reset_rvalid", W'(config_rvalid), '0);
        chk("reset_rdata", W'(config_rdata), '0);
        chk("reset_out", out_tracks, '0);
        chk("reset_pe_and", W'(pe_out), W'(tin(0, 0) & tin(1, 0)));
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int clb;
        int cb0;
        int cb1;
        int sbv [NSB];
        int id;
        int val;

        reset        = 1'b0;
        tile_id      = TILE;
        config_addr  = '0;
        config_data  = '0;
        config_valid = 1'b0;
        config_read  = 1'b0;
        in_tracks    = rand_tracks();
        model_clear();
        #1;
        do_reset();

        // Reset state and readback of every id, back to back.
        in_tracks = rand_tracks();
        #1 chk("post_reset_out", out_tracks, '0);
        for (int i = 4; i < 8 + NSB; i++) begin
            cfg_read(i);
            #1 chk("rb_zero", W'(config_rdata), '0);
        end
        cfg_read(16'hFFFF);
        #1 chk("rb_commit_zero", W'(config_rdata), '0);
        step();

        // SB(2,1) = side 3 pass-through, visible only after commit.
        in_tracks = rand_tracks();
        in_tracks[(3*NT + 1)*DW +: DW] = 8'h5A;
        cfg_write(8 + 2*NT + 1, 1);
        #1 chk("sb21_uncommitted", W'(out_tracks[(2*NT + 1)*DW +: DW]), '0);
        cfg_write(16'hFFFF, 0);
        #1 chk("sb21_committed", W'(out_tracks[(2*NT + 1)*DW +: DW]), W'(8'h5A));
        in_tracks[(3*NT + 1)*DW +: DW] = 8'hC3;
        #1 chk("sb21_comb_follow", W'(out_tracks[(2*NT + 1)*DW +: DW]), W'(8'hC3));
        cfg_read(8 + 2*NT + 1);
        #1 chk("sb21_readback", W'(config_rdata), W'(1));
        chk("sb21_rvalid", W'(config_rvalid), W'(1));
        step();
        #1 chk("rvalid_one_cycle", W'(config_rvalid), '0);

        // Registered PE path through SB(0,0), CLB ADD with carry dropped.
        cfg_write(8, 'hC);
        cfg_write(4, 3);
        cfg_write(6, 0);
        cfg_write(5, 0);
        cfg_write(16'hFFFF, 0);
        in_tracks[0 +: DW]        = 8'h90;
        in_tracks[NT*DW +: DW]    = 8'h85;
        #1 chk("pe_add_comb", W'(pe_out), W'(8'h15));
        step();
        #1 chk("sb00_reg_add", W'(out_tracks[0 +: DW]), W'(8'h15));
        in_tracks[0 +: DW]     = 8'h01;
        in_tracks[NT*DW +: DW] = 8'h02;
        #1 chk("sb00_reg_holds", W'(out_tracks[0 +: DW]), W'(8'h15));
        chk("pe_add_new", W'(pe_out), W'(8'h03));
        step();
        #1 chk("sb00_reg_next", W'(out_tracks[0 +: DW]), W'(8'h03));

        // Foreign tile and unmapped id writes, foreign commit.
        config_addr  = {16'h0006, 16'h0043};
        config_data  = 32'h7;
        config_valid = 1'b1;
        step();
        config_valid = 1'b0;
        cfg_write(7, 5);
        cfg_write(4, 0);
        config_addr  = {16'hFFFF, 16'h0043};
        config_valid = 1'b1;
        step();
        config_valid = 1'b0;
        #1 chk("foreign_commit_ignored", W'(pe_out), W'(8'h03));
        cfg_read(6);
        #1 chk("foreign_write_ignored", W'(config_rdata), '0);
        cfg_read(7);
        #1 chk("unmapped_read", W'(config_rdata), '0);
        cfg_read(4);
        #1 chk("clb_shadow", W'(config_rdata), '0);
        config_addr = {16'h0006, 16'h0043};
        config_read = 1'b1;
        step();
        config_read = 1'b0;
        #1 chk("foreign_read_no_rvalid", W'(config_rvalid), '0);

        // Read and write of the same id in one cycle, then read again.
        config_addr  = {16'd5, TILE};
        config_data  = 32'h2;
        config_valid = 1'b1;
        config_read  = 1'b1;
        step();
        config_valid = 1'b0;
        #1 chk("rw_same_old", W'(config_rdata), '0);
        chk("rw_same_rvalid", W'(config_rvalid), W'(1));
        step();
        config_read = 1'b0;
        #1 chk("rw_next_new", W'(config_rdata), W'(2));
        chk("rw_next_rvalid", W'(config_rvalid), W'(1));
        step();
        #1 chk("rw_rvalid_drop", W'(config_rvalid), '0);

        // Reset during configuration and with a readback pending.
        cfg_write(6, 3);
        cfg_read(6);
        #1 chk("pre_reset_rb", W'(config_rdata), W'(3));
        do_reset();
        in_tracks = rand_tracks();
        cfg_read(6);
        #1 chk("cb0_lost", W'(config_rdata), '0);
        chk("reset_cfg_out", out_tracks, '0);
        chk("reset_cfg_pe", W'(pe_out), W'(tin(0, 0) & tin(1, 0)));

        // Randomized loop-free configurations with random traffic and reads.
        for (int r = 0; r < 30; r++) begin
            clb = $urandom_range(0, 7);
            cb0 = $urandom_range(0, 7);
            cb1 = $urandom_range(0, 7);
            for (int i = 0; i < NSB; i++) sbv[i] = $urandom_range(0, 15);
            if (cb0 >= NT && (sbv[cb0 - NT] & 7) == 4) sbv[cb0 - NT] |= 8;
            if (cb1 >= NT && (sbv[cb1] & 7) == 4) sbv[cb1] |= 8;
            for (int i = 0; i < NSB + 3; i++) begin
                if (i < NSB) begin
                    id  = 8 + i;
                    val = sbv[i];
                end else if (i == NSB) begin
                    id  = 4;
                    val = clb;
                end else if (i == NSB + 1) begin
                    id  = 5;
                    val = cb1;
                end else begin
                    id  = 6;
                    val = cb0;
                end
                in_tracks   = rand_tracks();
                config_read = ($urandom_range(0, 2) == 0);
                cfg_write(id, val | int'($urandom_range(0, 255) << 8));
            end
            config_read = 1'b0;
            cfg_write(16'hFFFF, 0);
            for (int c = 0; c < 6; c++) begin
                in_tracks = rand_tracks();
                if ($urandom_range(0, 1) == 1) begin
                    config_addr = {16'($urandom_range(0, 26)), TILE};
                    config_read = 1'b1;
                end else begin
                    config_read = 1'b0;
                end
                step();
            end
            config_read = 1'b0;
        end
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pe_tile_param.md
# pe_tile_param

Parametrised processing-element tile for the island-style fabric. It generalises the fixed 1-bit, 4-track tile in three ways: configurable data width and track count, per-output pipeline registers in the switch box, and double-buffered configuration with atomic commit and readback. It holds a disjoint switch box, two connect boxes (sides 0 and 1) and a CLB, and is tiled by the array generator through flattened per-side track buses.

## Interface
- DATA_WIDTH, 1: bits per track and per PE operand/result.
- NUM_TRACKS, 4: tracks per side (≥2); CB_SEL_W = clog2(2*NUM_TRACKS) derived.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- tile_id  in  16  tile address.
- config_addr  in  32  [15:0] tile id, [31:16] sub-block id.
- config_data  in  32  write data.
- config_valid  in  1  write strobe.
- config_read  in  1  read strobe.
- config_rdata  out  32  readback data.
- config_rvalid  out  1  readback valid.
- in_tracks  in  4*NUM_TRACKS*DATA_WIDTH  side s, track t at [(s*NUM_TRACKS+t)*DATA_WIDTH +: DATA_WIDTH].
- out_tracks  out  4*NUM_TRACKS*DATA_WIDTH  same packing.
- pe_out  out  DATA_WIDTH  CLB result (observation/debug).

## Operation
- Address hit: config_addr[15:0]==tile_id. Sub-block ids: 4 CLB, 5 CB1, 6 CB0, 8+s*NUM_TRACKS+t SB entry (s,t), 0xFFFF commit. Other ids are unmapped.
- Write: config_valid & hit & mapped id -> shadow register gets config_data low bits. Unmapped ids are ignored.
- Commit: config_valid & hit & id 0xFFFF -> every active register takes its shadow value on the same edge. Only active registers drive the datapath.
- Read: config_read & hit -> config_rdata = zero-extended shadow value for that id. Unmapped ids and commit read 0.
- SB entry (4 bits): [2:0] sel, [3] reg.
  - sel 0: drive 0.
  - sel 1..3: in_tracks side (s+sel)%4, track t.
  - sel 4: pe_out.
  - sel 5..7: drive 0.
  - reg=1: output goes through a DATA_WIDTH register updated every cycle. reg=0: combinational.
- CBk (k=0,1, side k), CB_SEL_W bits:
  - sel < NUM_TRACKS: in_tracks(k, sel).
  - sel ≥ NUM_TRACKS: out_tracks(k, sel-NUM_TRACKS).
  - Result is op_k.
- CLB (3 bits): [1:0] op: 0 AND, 1 OR, 2 XOR, 3 ADD mod 2^DATA_WIDTH, carry dropped. [2] reg: register pe_out.
- Combinational loops are possible through unregistered paths and are legal; the configurer avoids them.

## Timing
- Reset (reset=0, asynchronous): all shadow, active and pipeline registers clear. config_rvalid=0, config_rdata=0, out_tracks=0, pe_out=AND of CB side-0 track-0 selections.
- Write: shadow updated at the edge. Datapath unchanged until commit.
- Commit: new config drives the datapath from the edge onward. A registered output shows its first new-source value one edge later.
- Write and commit in the same cycle are impossible (one address). Write to an id, then commit on the next valid cycle; no gap is required.
- Read: config_rvalid=1 and config_rdata valid the cycle after the strobe, for exactly one cycle. Back-to-back reads are supported at one per cycle.
- Read and write in the same cycle to the same id: the read returns the pre-write value.
- config_read is honoured regardless of config_valid.
- Registered SB/CLB paths: latency 1 cycle. Unregistered paths: 0.
- Reset asserted mid-sequence: uncommitted shadow writes are lost, and a pending rvalid is dropped.

## Test plan
- Reset, then sample: out_tracks=0, config_rvalid=0, config_rdata=0; readback of every id returns 0.
- Write SB(2,1)=0x1, no commit -> out(2,1) stays 0. Commit -> out(2,1) follows in(3,1) combinationally. Readback id 8+2*NUM_TRACKS+1 returns 0x1.
- SB(0,0)=0xC (reg, PE): CLB op ADD, DATA_WIDTH=8. CB0 selects in(0,0)=0x90, CB1 selects in(1,0)=0x85 -> out(0,0)=0x15 one cycle after the operands are applied.
- Write to another tile_id or an unmapped id 0x7 -> shadow is unchanged, readback returns 0, and no commit side effect.
- Read, then write the same id in the same cycle -> config_rdata is the old value. Read on the next cycle -> the new value, with rvalid high for one cycle each time.
- Mid-config reset: write CB0=3, assert reset before commit, release -> CB0 readback returns 0 and the datapath is in its reset configuration.
